// File: rtl/ins_fetcher.sv
// Sequential-PC instruction fetcher: one outstanding memory request, a small
// {pc, ins} queue, and single-pulse delivery to the decoder with stall/clear.
module ins_fetcher #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IQ_DEPTH_BIT = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        ins_ready,
    output logic [31:0] ins,
    output logic [31:0] pc,
    input  logic        DEC_stall,
    input  logic        DEC_clear,
    input  logic [31:0] DEC_new_addr,
    output logic        MEM_req_valid,
    output logic [31:0] MEM_req_addr,
    input  logic        MEM_grant,
    input  logic        MEM_resp_valid,
    input  logic [31:0] MEM_resp_data
);
    localparam int DEPTH = 1 << IQ_DEPTH_BIT;
    localparam int CW    = IQ_DEPTH_BIT + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t                  state_r, state_nx_s;
    logic [31:0]             fetch_pc_r, fetch_pc_nx_s;
    logic                    req_valid_nx_s;
    logic [31:0]             req_addr_nx_s;
    logic [31:0]             q_pc_r  [DEPTH];
    logic [31:0]             q_ins_r [DEPTH];
    logic [IQ_DEPTH_BIT-1:0] head_r, tail_r;
    logic [CW-1:0]           count_r, count_nx_s;
    logic                    pop_s, push_s, room_s;

    // Queue handshakes for this cycle; a clear suppresses both pop and push.
    always_comb begin
        pop_s      = (count_r != {CW{1'b0}}) && !DEC_stall && !DEC_clear;
        push_s     = (state_r == ST_WAIT) && MEM_resp_valid && !DEC_clear;
        count_nx_s = count_r + CW'(push_s) - CW'(pop_s);
        room_s     = (count_nx_s < CW'(DEPTH));
    end

    // Fetch FSM next-state, request and fetch-PC update.
    always_comb begin
        state_nx_s     = state_r;
        req_valid_nx_s = MEM_req_valid;
        req_addr_nx_s  = MEM_req_addr;
        if (DEC_clear) begin
            fetch_pc_nx_s = {DEC_new_addr[31:2], 2'b00};
        end else if (push_s) begin
            fetch_pc_nx_s = fetch_pc_r + 32'd4;
        end else begin
            fetch_pc_nx_s = fetch_pc_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (!DEC_clear && room_s) begin
                    req_valid_nx_s = 1'b1;
                    req_addr_nx_s  = fetch_pc_r;
                    state_nx_s     = ST_REQ;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (MEM_grant) begin
                    req_valid_nx_s = 1'b0;
                    state_nx_s     = DEC_clear ? ST_DROP : ST_WAIT;
                end else if (DEC_clear) begin
                    req_valid_nx_s = 1'b0;
                    state_nx_s     = ST_IDLE;
                end else begin
                    state_nx_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                // A response coinciding with a clear is simply not pushed.
                if (MEM_resp_valid) begin
                    state_nx_s = ST_IDLE;
                end else if (DEC_clear) begin
                    state_nx_s = ST_DROP;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (MEM_resp_valid) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DROP;
                end
            end
            default: begin
                req_valid_nx_s = 1'b0;
                state_nx_s     = ST_IDLE;
            end
        endcase
    end

    // Control state, pointers and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r       <= ST_IDLE;
            fetch_pc_r    <= RESET_PC;
            MEM_req_valid <= 1'b0;
            MEM_req_addr  <= 32'd0;
            head_r        <= {IQ_DEPTH_BIT{1'b0}};
            tail_r        <= {IQ_DEPTH_BIT{1'b0}};
            count_r       <= {CW{1'b0}};
            ins_ready     <= 1'b0;
            ins           <= 32'd0;
            pc            <= 32'd0;
        end else if (rdy_in) begin
            state_r       <= state_nx_s;
            fetch_pc_r    <= fetch_pc_nx_s;
            MEM_req_valid <= req_valid_nx_s;
            MEM_req_addr  <= req_addr_nx_s;
            if (DEC_clear) begin
                head_r  <= {IQ_DEPTH_BIT{1'b0}};
                tail_r  <= {IQ_DEPTH_BIT{1'b0}};
                count_r <= {CW{1'b0}};
            end else begin
                head_r  <= head_r + IQ_DEPTH_BIT'(pop_s);
                tail_r  <= tail_r + IQ_DEPTH_BIT'(push_s);
                count_r <= count_nx_s;
            end
            ins_ready <= pop_s;
            if (pop_s) begin
                ins <= q_ins_r[head_r];
                pc  <= q_pc_r[head_r];
            end else begin
                ins <= ins;
                pc  <= pc;
            end
        end else begin
            ins_ready <= 1'b0;
        end
    end

    // Queue storage; contents need no reset since count gates every read.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && push_s) begin
            q_pc_r[tail_r]  <= fetch_pc_r;
            q_ins_r[tail_r] <= MEM_resp_data;
        end
    end
endmodule
